// File: rtl/rr_arbiter.sv
// N-way registered arbiter with fixed or round-robin priority, grant locking
// while the owner keeps requesting, and an optional hold limit that forces rotation.
module rr_arbiter #(
  parameter int N        = 8,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [IW:0]   NV        = (IW + 1)'(N);
  localparam logic [N-1:0]  ONE       = {{(N - 1){1'b0}}, 1'b1};
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  gnt_d;
  logic [IW-1:0] id_d;

  logic [N-1:0]  others;
  logic [IW-1:0] start;
  logic [IW:0]   cand;
  logic [IW:0]   after_win;
  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] win_ptr;
  logic          owner_req;
  logic          timeout;
  logic          take;

  // The owner's own bit is masked out of the search: when the owner has dropped
  // its request the mask changes nothing, and on timeout it excludes the owner.
  always_comb begin
    others = req & ~gnt;
    start  = (MODE != 0) ? ptr_q : '0;
    found  = 1'b0;
    win    = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, start} + (IW + 1)'(k);
      if (cand >= NV) cand = cand - NV;
      if (!found && others[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
    after_win = {1'b0, win} + 1'b1;
    win_ptr   = (after_win == NV) ? '0 : after_win[IW-1:0];
  end

  assign owner_req = |(req & gnt);
  assign timeout   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt;
    id_d    = gnt_id;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) take = 1'b1;
      end
      OWNED: begin
        if (!owner_req) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            hold_d  = '0;
          end
        end else if (timeout) begin
          // Sole requester at the limit keeps the grant with a fresh window.
          if (found) take = 1'b1;
          else       hold_d = '0;
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = OWNED;
      gnt_d   = ONE << win;
      id_d    = win;
      hold_d  = '0;
      if (MODE != 0) ptr_d = win_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_valid <= (state_d == OWNED);
      gnt_id    <= id_d;
    end
  end

endmodule
